// File: rtl/sip_shift_accumulator.sv
// sip_shift_accumulator
// Shift-accumulates a programmed number of signed bit-slice partial sums
// from the dot-adder tree into one wide signed result. Each accepted beat
// is sign-extended, shifted left by its slice significance and added with
// two's-complement wrap. A sticky flag records any signed overflow in the
// current job. The result is offered downstream on a valid/ready handshake.
module sip_shift_accumulator #(
   parameter int BITS_IN    = 9,
   parameter int BITS_ACC   = 24,
   parameter int BITS_SHIFT = 4,
   parameter int BITS_CNT   = 8
) (
   input  logic                  i_CLK,
   input  logic                  i_RSTn,
   input  logic                  i_Clear,
   input  logic                  i_Start,
   input  logic [BITS_CNT-1:0]   i_NumSteps,
   input  logic                  i_Valid,
   output logic                  o_InReady,
   input  logic [BITS_IN-1:0]    i_Psum,
   input  logic [BITS_SHIFT-1:0] i_Shift,
   output logic                  o_Valid,
   input  logic                  i_Ready,
   output logic [BITS_ACC-1:0]   o_Result,
   output logic                  o_Ovf,
   output logic                  o_Busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [BITS_ACC-1:0]   r_acc;
   logic [BITS_CNT-1:0]   r_cnt;
   logic [BITS_CNT-1:0]   r_num;
   logic                  r_ovf;

   logic                  w_beat;
   logic                  w_last;
   logic                  w_start;
   logic [BITS_ACC-1:0]   w_psum_ext;
   logic [BITS_ACC-1:0]   w_term;
   logic [BITS_ACC-1:0]   w_sum;
   logic                  w_ovf;

   // A beat is only taken while accumulating; beats offered elsewhere are dropped.
   assign w_beat     = (r_state == S_ACC) && i_Valid;
   assign w_start    = (r_state == S_IDLE) && i_Start;
   // Only evaluated in ACC, where the latched step count is at least one.
   assign w_last     = (r_cnt == r_num - BITS_CNT'(1));

   // Sign-extend first, then shift, so slice bits pushed past the MSB are lost.
   assign w_psum_ext = {{(BITS_ACC - BITS_IN){i_Psum[BITS_IN-1]}}, i_Psum};
   assign w_term     = w_psum_ext << i_Shift;
   assign w_sum      = r_acc + w_term;
   // Signed overflow: operands agree in sign but the wrapped sum does not.
   assign w_ovf      = (r_acc[BITS_ACC-1] == w_term[BITS_ACC-1]) &&
                       (w_sum[BITS_ACC-1] != r_acc[BITS_ACC-1]);

   // State register; reset and clear both force the job back to IDLE.
   always_ff @(posedge i_CLK) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (!i_RSTn || i_Clear) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: start, last beat and downstream handshake move the job along.
   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_Start) begin
               w_next = (i_NumSteps == '0) ? S_DONE : S_ACC;
            end
         end
         S_ACC: begin
            if (w_beat && w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            if (i_Ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: job setup on start, accumulate on each accepted beat, otherwise hold.
   always_ff @(posedge i_CLK) begin
      if (!i_RSTn || i_Clear) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_num <= '0;
         r_ovf <= 1'b0;
      end else if (w_start) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_num <= i_NumSteps;
         r_ovf <= 1'b0;
      end else if (w_beat) begin
         r_acc <= w_sum;
         r_cnt <= r_cnt + BITS_CNT'(1);
         r_ovf <= r_ovf | w_ovf;
      end
   end

   // Outputs decode directly from registered state; the result stays visible
   // in IDLE after a handshake until the next start clears it.
   assign o_InReady = (r_state == S_ACC);
   assign o_Valid   = (r_state == S_DONE);
   assign o_Busy    = (r_state != S_IDLE);
   assign o_Result  = r_acc;
   assign o_Ovf     = r_ovf;

endmodule

// File: tb/tb_sip_shift_accumulator.sv
// Directed bench for sip_shift_accumulator: hand-computed results for
// ordinary jobs, zero-length jobs, valid gaps, backpressure, overflow,
// clear and reset.
module tb_sip_shift_accumulator;

   localparam int BITS_IN    = 9;
   localparam int BITS_ACC   = 24;
   localparam int BITS_SHIFT = 4;
   localparam int BITS_CNT   = 8;

   logic                  clk;
   logic                  rst_n;
   logic                  i_clear;
   logic                  i_start;
   logic [BITS_CNT-1:0]   i_num;
   logic                  i_valid;
   logic                  o_in_ready;
   logic [BITS_IN-1:0]    i_psum;
   logic [BITS_SHIFT-1:0] i_shift;
   logic                  o_valid;
   logic                  i_ready;
   logic [BITS_ACC-1:0]   o_result;
   logic                  o_ovf;
   logic                  o_busy;

   int total = 0;
   int bad   = 0;

   sip_shift_accumulator #(
      .BITS_IN    (BITS_IN),
      .BITS_ACC   (BITS_ACC),
      .BITS_SHIFT (BITS_SHIFT),
      .BITS_CNT   (BITS_CNT)
   ) dut (
      .i_CLK      (clk),
      .i_RSTn     (rst_n),
      .i_Clear    (i_clear),
      .i_Start    (i_start),
      .i_NumSteps (i_num),
      .i_Valid    (i_valid),
      .o_InReady  (o_in_ready),
      .i_Psum     (i_psum),
      .i_Shift    (i_shift),
      .o_Valid    (o_valid),
      .i_Ready    (i_ready),
      .o_Result   (o_result),
      .o_Ovf      (o_ovf),
      .o_Busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [BITS_ACC-1:0] obs,
                        input logic [BITS_ACC-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one beat and clock it in.
   task automatic beat(input int p, input int s, input logic v);
      i_psum  = BITS_IN'(p);
      i_shift = BITS_SHIFT'(s);
      i_valid = v;
      tick();
   endtask

   task automatic flags(input string tag, input logic v, input logic rdy,
                        input logic busy);
      check({tag, "_valid"}, 24'(o_valid), 24'(v));
      check({tag, "_inrdy"}, 24'(o_in_ready), 24'(rdy));
      check({tag, "_busy"},  24'(o_busy), 24'(busy));
   endtask

   initial begin
      rst_n   = 1'b0;
      i_clear = 1'b0;
      i_start = 1'b0;
      i_num   = '0;
      i_valid = 1'b0;
      i_psum  = '0;
      i_shift = '0;
      i_ready = 1'b0;
      tick();
      tick();
      flags("reset", 1'b0, 1'b0, 1'b0);
      check("reset_res", o_result, 24'd0);
      check("reset_ovf", 24'(o_ovf), 24'd0);
      rst_n = 1'b1;
      tick();

      // Job 1: N=3, (5,0),(-3,2),(7,4) -> 5 - 12 + 112 = 105
      i_start = 1'b1;
      i_num   = 8'd3;
      tick();
      i_start = 1'b0;
      flags("j1_acc", 1'b0, 1'b1, 1'b1);
      beat(5, 0, 1'b1);
      check("j1_b1", o_result, 24'd5);
      beat(-3, 2, 1'b1);
      check("j1_b2", o_result, 24'(-7));
      flags("j1_mid", 1'b0, 1'b1, 1'b1);
      beat(7, 4, 1'b1);
      flags("j1_done", 1'b1, 1'b0, 1'b1);
      check("j1_res", o_result, 24'd105);
      check("j1_ovf", 24'(o_ovf), 24'd0);
      i_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      flags("j1_idle", 1'b0, 1'b0, 1'b0);
      check("j1_hold", o_result, 24'd105);

      // Job 2: N=0 goes straight to DONE with result 0
      i_start = 1'b1;
      i_num   = 8'd0;
      tick();
      i_start = 1'b0;
      flags("j2_done", 1'b1, 1'b0, 1'b1);
      check("j2_res", o_result, 24'd0);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      flags("j2_idle", 1'b0, 1'b0, 1'b0);

      // Job 3: N=4, valid pattern 1,0,0,1,1,0,1; stray starts ignored.
      // Valid beats: 10<<1=20, -4<<3=-32, 3, 1<<4=16 -> 7
      i_start = 1'b1;
      i_num   = 8'd4;
      tick();
      i_num   = 8'd1;
      beat(10, 1, 1'b1);
      beat(100, 5, 1'b0);
      i_start = 1'b0;
      beat(-77, 2, 1'b0);
      beat(-4, 3, 1'b1);
      i_start = 1'b1;
      beat(3, 0, 1'b1);
      check("j3_part", o_result, 24'(-9));
      beat(120, 6, 1'b0);
      i_start = 1'b0;
      flags("j3_acc", 1'b0, 1'b1, 1'b1);
      beat(1, 4, 1'b1);
      flags("j3_done", 1'b1, 1'b0, 1'b1);
      check("j3_res", o_result, 24'd7);

      // Backpressure: 5 cycles in DONE with beats offered and no ready
      for (int i = 0; i < 5; i++) begin
         beat(50, 1, 1'b1);
         flags("bp", 1'b1, 1'b0, 1'b1);
         check("bp_res", o_result, 24'd7);
      end
      i_valid = 1'b0;
      // Handshake with a simultaneous start: start must be ignored
      i_ready = 1'b1;
      i_start = 1'b1;
      i_num   = 8'd2;
      tick();
      i_ready = 1'b0;
      i_start = 1'b0;
      flags("hs_idle", 1'b0, 1'b0, 1'b0);
      tick();
      flags("hs_stay", 1'b0, 1'b0, 1'b0);
      check("hs_res", o_result, 24'd7);

      // Overflow: (255,15) twice, 8355840 each, wraps to -65536
      i_start = 1'b1;
      i_num   = 8'd2;
      tick();
      i_start = 1'b0;
      beat(255, 15, 1'b1);
      check("ov_b1", o_result, 24'd8355840);
      check("ov_b1_flag", 24'(o_ovf), 24'd0);
      beat(255, 15, 1'b1);
      i_valid = 1'b0;
      flags("ov_done", 1'b1, 1'b0, 1'b1);
      check("ov_res", o_result, 24'(-65536));
      check("ov_flag", 24'(o_ovf), 24'd1);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check("ov_hold", 24'(o_ovf), 24'd1);

      // Clear mid-job after 2 of 4 beats
      i_start = 1'b1;
      i_num   = 8'd4;
      tick();
      i_start = 1'b0;
      check("cl_ovf_start", 24'(o_ovf), 24'd0);
      beat(1, 0, 1'b1);
      beat(2, 0, 1'b1);
      check("cl_part", o_result, 24'd3);
      i_valid = 1'b0;
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      flags("cl_idle", 1'b0, 1'b0, 1'b0);
      check("cl_res", o_result, 24'd0);

      // New job N=1 with (-256,0)
      i_start = 1'b1;
      i_num   = 8'd1;
      tick();
      i_start = 1'b0;
      beat(-256, 0, 1'b1);
      i_valid = 1'b0;
      flags("n1_done", 1'b1, 1'b0, 1'b1);
      check("n1_res", o_result, 24'(-256));

      // Reset while in DONE clears everything
      rst_n = 1'b0;
      tick();
      flags("rst_done", 1'b0, 1'b0, 1'b0);
      check("rst_res", o_result, 24'd0);
      check("rst_ovf", 24'(o_ovf), 24'd0);
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
